// File: rtl/qalu_seq.sv
// qalu_seq: registered ALU with valid/ready handshakes on input and output.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/CMP) produce a result one cycle
// after acceptance; MUL is a WIDTH-cycle shift-add.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, select sampled on accept)
//   a, b                  WIDTH-bit unsigned operands
//   select                3-bit opcode
//   out_valid/out_ready   result handshake
//   out                   2*WIDTH-bit registered result
//   carry, zero           result flags (carry = add carry / sub borrow)
//   busy                  high while a multiply is in progress
module qalu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 carry,
    output logic                 zero,
    output logic                 busy
);

    localparam int unsigned OUT_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic [OUT_W-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [OUT_W-1:0]    a_ext, b_ext;
    logic [OUT_W-1:0]    alu_res;
    logic                alu_carry;
    logic [OUT_W-1:0]    acc_next;

    // HOLD can take a new op in the same cycle its result is consumed
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_MUL);
    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

    // Single-cycle datapath
    always_comb begin
        a_ext     = OUT_W'(a);
        b_ext     = OUT_W'(b);
        alu_res   = '0;
        alu_carry = 1'b0;
        case (select)
            OP_ADD: begin
                alu_res   = a_ext + b_ext;
                alu_carry = alu_res[WIDTH];
            end
            OP_SUB: begin
                alu_res   = a_ext - b_ext;
                alu_carry = (a < b);
            end
            OP_AND:  alu_res = a_ext & b_ext;
            OP_OR:   alu_res = a_ext | b_ext;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_SHL:  alu_res = a_ext << b;
            OP_CMP: begin
                if (a > b)       alu_res = OUT_W'(2);
                else if (a == b) alu_res = OUT_W'(1);
                else             alu_res = '0;
            end
            default: alu_res = '0;
        endcase
    end

    // Partial product including the current multiplier bit
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = acc_next;
                    zero_d  = (acc_next == '0);
                    carry_d = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance overrides the consume transition out of HOLD
        if (accept) begin
            if (select == OP_MUL) begin
                mcand_d  = a_ext;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = CNT_W'(WIDTH);
                state_d  = S_MUL;
            end else begin
                out_d    = alu_res;
                carry_d  = alu_carry;
                zero_d   = (alu_res == '0);
                state_d  = S_HOLD;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_qalu_seq.sv
// tb_qalu_seq: self-checking bench for qalu_seq (WIDTH=4) with directed
// scenarios and randomized operations compared against an arithmetic model.
module tb_qalu_seq;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned OUT_W = 2 * WIDTH;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             carry;
    logic             zero;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    qalu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: returns {carry, out} computed with plain integer arithmetic
    function automatic logic [OUT_W:0] model(input int op, input int av, input int bv);
        int r;
        bit c;
        c = 1'b0;
        r = 0;
        case (op)
            0: begin r = av + bv; c = (r >= (1 << WIDTH)); end
            1: begin r = av - bv; c = (av < bv); if (r < 0) r = r + (1 << OUT_W); end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = (av << bv) % (1 << OUT_W);
            6: r = (av > bv) ? 2 : ((av == bv) ? 1 : 0);
            default: r = av * bv;
        endcase
        return {c, OUT_W'(r)};
    endfunction

    // Present an op and hold it until accepted; returns at the negedge after acceptance
    task automatic drive_op(input int op, input int av, input int bv, output bit ok);
        in_valid = 1'b1;
        select   = 3'(op);
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; select = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out, carry, zero, out_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h c=%b z=%b v=%b busy=%b, expected all 0",
                     out, carry, zero, out_valid, busy);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_add;
        bit ok;
        out_ready = 1'b1;
        drive_op(0, 9, 8, ok);
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out !== 8'h11 || carry !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_9_8: got ok=%b v=%b out=%h c=%b z=%b, expected v=1 out=11 c=1 z=0",
                     ok, out_valid, out, carry, zero);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out !== 8'h11) begin
            n_fail++;
            $display("FAIL add_consume: got v=%b out=%h, expected v=0 out=11", out_valid, out);
        end
    endtask

    task automatic test_sub;
        bit ok;
        drive_op(1, 3, 5, ok);
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out !== 8'hFE || carry !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_3_5: got v=%b out=%h c=%b z=%b, expected v=1 out=fe c=1 z=0",
                     out_valid, out, carry, zero);
        end
        drive_op(1, 5, 5, ok);
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_5_5: got v=%b out=%h c=%b z=%b, expected v=1 out=00 c=0 z=1",
                     out_valid, out, carry, zero);
        end
    endtask

    task automatic test_mul;
        bit ok;
        drive_op(7, 15, 15, ok);
        for (int i = 0; i < int'(WIDTH); i++) begin
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy[%0d]: got busy=%b in_ready=%b v=%b, expected 1 0 0",
                         i, busy, in_ready, out_valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok || out_valid !== 1'b1 || busy !== 1'b0 || out !== 8'hE1 || carry !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_15_15: got v=%b busy=%b out=%h c=%b z=%b, expected v=1 busy=0 out=e1 c=0 z=0",
                     out_valid, busy, out, carry, zero);
        end
        drive_op(7, 0, 7, ok);
        wait_valid(ok);
        n_checks++;
        if (!ok || out !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_0_7: got ok=%b out=%h z=%b c=%b, expected out=00 z=1 c=0", ok, out, zero, carry);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        out_ready = 1'b0;
        drive_op(6, 2, 7, ok);
        // Junk op offered while held must be ignored
        in_valid = 1'b1; select = 3'd0; a = 4'd15; b = 4'd15;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out !== 8'h00 || in_ready !== 1'b0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b out=%h in_ready=%b z=%b, expected v=1 out=00 in_ready=0 z=1",
                         i, out_valid, out, in_ready, zero);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        select = 3'd0; a = 4'd1; b = 4'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 8'h02 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL consume_accept: got v=%b out=%h c=%b, expected v=1 out=02 c=0", out_valid, out, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ops[8];
        int av[8];
        int bv[8];
        logic [OUT_W:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ops[i] = int'($urandom_range(0, 6));
            av[i]  = int'($urandom_range(0, 15));
            bv[i]  = int'($urandom_range(0, 15));
        end
        in_valid = 1'b1; select = 3'(ops[0]); a = WIDTH'(av[0]); b = WIDTH'(bv[0]);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
            end
            @(negedge clk);
            exp = model(ops[i], av[i], bv[i]);
            n_checks++;
            if (out_valid !== 1'b1 || out !== exp[OUT_W-1:0] || carry !== exp[OUT_W]) begin
                n_fail++;
                $display("FAIL stream[%0d] op=%0d a=%0d b=%0d: got v=%b out=%h c=%b, expected v=1 out=%h c=%b",
                         i, ops[i], av[i], bv[i], out_valid, out, carry, exp[OUT_W-1:0], exp[OUT_W]);
            end
            if (i < 7) begin
                select = 3'(ops[i+1]); a = WIDTH'(av[i+1]); b = WIDTH'(bv[i+1]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        bit ok;
        logic [OUT_W:0] exp;
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            for (int x = 1; x <= 3; x++) begin
                for (int y = 1; y <= 3; y++) begin
                    drive_op(op, x, y, ok);
                    wait_valid(ok);
                    exp = model(op, x, y);
                    n_checks++;
                    if (!ok || out !== exp[OUT_W-1:0] || carry !== exp[OUT_W] ||
                        zero !== (exp[OUT_W-1:0] == '0)) begin
                        n_fail++;
                        $display("FAIL sweep op=%0d a=%0d b=%0d: got ok=%b out=%h c=%b z=%b, expected out=%h c=%b",
                                 op, x, y, ok, out, carry, zero, exp[OUT_W-1:0], exp[OUT_W]);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        bit ok;
        int op, x, y;
        logic [OUT_W:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            x  = int'($urandom_range(0, 15));
            y  = int'($urandom_range(0, 15));
            drive_op(op, x, y, ok);
            wait_valid(ok);
            exp = model(op, x, y);
            n_checks++;
            if (!ok || out !== exp[OUT_W-1:0] || carry !== exp[OUT_W] ||
                zero !== (exp[OUT_W-1:0] == '0)) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d: got ok=%b out=%h c=%b z=%b, expected out=%h c=%b",
                         i, op, x, y, ok, out, carry, zero, exp[OUT_W-1:0], exp[OUT_W]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        bit ok;
        out_ready = 1'b1;
        drive_op(0, 1, 4, ok);
        drive_op(7, 13, 11, ok);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mul_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || carry !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mul_reset: got out=%h v=%b busy=%b c=%b z=%b, expected all 0",
                     out, out_valid, busy, carry, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got in_ready=%b v=%b, expected 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        drive_op(0, 1, 2, ok);
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out !== 8'h03 || carry !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_add: got v=%b out=%h c=%b z=%b, expected v=1 out=03 c=0 z=0",
                     out_valid, out, carry, zero);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        test_random();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
